// File: rtl/im_fetch_server.sv
// im_fetch_server: responder side of the instruction-fetch interface.
// Accepts one PC request at a time and returns the instruction word LATENCY
// cycles after accept through a valid/ready response. A loader port can write
// the instruction array at any time, including while reset is asserted.
// Optional build macro: IM_FETCH_PERF_EN adds fetch/stall performance counters.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a request; req_ready_o high
// WAIT  | latency countdown; word read on the cycle where cnt reaches 0
// RESP  | response held on rsp_* until rsp_ready_i is seen
module im_fetch_server #(
    parameter int          ADDR_W    = 12,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [31:0]       req_pc_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_instr_o,
    output logic [31:0]       rsp_pc_o,
    output logic              rsp_err_o,
    input  logic              ld_we_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [31:0]       ld_data_i
`ifdef IM_FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt_o,
    output logic [31:0]       perf_stall_cnt_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Byte span of the array; 33 bits so the bound cannot overflow.
    localparam logic [32:0] MEM_BYTES = 33'd4 << ADDR_W;
    localparam logic [3:0]  LAT_M1    = 4'(LATENCY - 1);

    logic [31:0] mem_q [2**ADDR_W];

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] rpc_q, rpc_d;
    logic        err_q, err_d;

    logic [31:0]       rd_off;
    logic [ADDR_W-1:0] rd_idx;
    logic              rd_err;
    logic [31:0]       rd_word;

    // Loader writes are independent of reset and FSM state.
    always_ff @(posedge clk_i) begin
        if (ld_we_i) begin
            mem_q[ld_addr_i] <= ld_data_i;
        end
    end

    // Address check and write-first read of the captured PC.
    always_comb begin
        rd_off  = pc_q - BASE_ADDR;
        rd_idx  = rd_off[ADDR_W+1:2];
        rd_err  = (pc_q[1:0] != 2'b00) || (pc_q < BASE_ADDR) ||
                  ({1'b0, rd_off} >= MEM_BYTES);
        rd_word = (ld_we_i && (ld_addr_i == rd_idx)) ? ld_data_i : mem_q[rd_idx];
    end

    // State register and response holding registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            pc_q    <= 32'd0;
            instr_q <= 32'd0;
            rpc_q   <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            rpc_q   <= rpc_d;
            err_q   <= err_d;
        end
    end

    // Next-state, countdown and handshake outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        rpc_d       = rpc_q;
        err_d       = err_q;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    pc_d    = req_pc_i;
                    cnt_d   = LAT_M1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    instr_d = rd_err ? 32'd0 : rd_word;
                    rpc_d   = pc_q;
                    err_d   = rd_err;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rsp_instr_o = instr_q;
    assign rsp_pc_o    = rpc_q;
    assign rsp_err_o   = err_q;

`ifdef IM_FETCH_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    // Completed fetches and RESP cycles spent waiting on the fetch unit.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            if (rsp_valid_o && rsp_ready_i) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if ((state_q == S_RESP) && !rsp_ready_i) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt_o = fetch_cnt_q;
    assign perf_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_im_fetch_server.sv
// Bench for im_fetch_server: directed cases plus randomized fetches checked
// against a word-array model of the instruction memory.
module tb_im_fetch_server;
    localparam int          ADDR_W  = 12;
    localparam int          LATENCY = 2;
    localparam logic [31:0] BASE    = 32'h0000_3000;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_pc;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_instr;
    logic [31:0]       rsp_pc;
    logic              rsp_err;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [31:0]       ld_data;
`ifdef IM_FETCH_PERF_EN
    logic [31:0]       perf_fetch_cnt;
    logic [31:0]       perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    im_fetch_server #(.ADDR_W(ADDR_W), .LATENCY(LATENCY), .BASE_ADDR(BASE)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_pc_i    (req_pc),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_instr_o (rsp_instr),
        .rsp_pc_o    (rsp_pc),
        .rsp_err_o   (rsp_err),
        .ld_we_i     (ld_we),
        .ld_addr_i   (ld_addr),
        .ld_data_i   (ld_data)
`ifdef IM_FETCH_PERF_EN
        ,
        .perf_fetch_cnt_o (perf_fetch_cnt),
        .perf_stall_cnt_o (perf_stall_cnt)
`endif
    );

    logic [31:0] ref_mem [2**ADDR_W];
    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned mdl_fetch = 0;
    int unsigned mdl_stall = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_err(input logic [31:0] pc);
        longint p;
        p = longint'(pc);
        return (p % 4 != 0) || (p < longint'(BASE)) ||
               (p - longint'(BASE) >= 4 * (longint'(1) << ADDR_W));
    endfunction

    function automatic logic [ADDR_W-1:0] ref_idx(input logic [31:0] pc);
        logic [31:0] w;
        w = (pc - BASE) / 4;
        return w[ADDR_W-1:0];
    endfunction

    // One complete fetch: accept, latency count, response held for 'stall'
    // cycles with rsp_ready low, then consumed. Optional write on the final
    // WAIT cycle to the word being fetched.
    task automatic fetch(input logic [31:0] pc, input int stall,
                         input bit wb, input logic [31:0] wb_data);
        int          n;
        bit          e;
        logic [31:0] exp_instr;
        chk("idle_ready", {31'd0, req_ready}, 32'd1);
        chk("idle_valid", {31'd0, rsp_valid}, 32'd0);
        req_valid = 1'b1;
        req_pc    = pc;
        @(negedge clk);
        req_valid = 1'b0;
        req_pc    = $urandom;
        e = ref_err(pc);
        n = 0;
        while (!rsp_valid && n < 40) begin
            chk("wait_ready", {31'd0, req_ready}, 32'd0);
            rsp_ready = 1'($urandom % 2);
            if (wb && n == LATENCY - 1) begin
                ld_we   = 1'b1;
                ld_addr = ref_idx(pc);
                ld_data = wb_data;
                ref_mem[ref_idx(pc)] = wb_data;
            end
            @(negedge clk);
            ld_we = 1'b0;
            n++;
        end
        chk("latency", n, LATENCY);
        exp_instr = e ? 32'd0 : ref_mem[ref_idx(pc)];
        rsp_ready = 1'b0;
        for (int i = 0; i <= stall; i++) begin
            chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("rsp_instr", rsp_instr, exp_instr);
            chk("rsp_pc", rsp_pc, pc);
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, e});
            chk("resp_ready", {31'd0, req_ready}, 32'd0);
            if (i == stall) rsp_ready = 1'b1;
            else mdl_stall++;
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        mdl_fetch++;
        chk("post_valid", {31'd0, rsp_valid}, 32'd0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mdl_fetch = 0;
        mdl_stall = 0;
    endtask

    task automatic chk_perf(input string tag);
`ifdef IM_FETCH_PERF_EN
        chk({tag, "_fetch"}, perf_fetch_cnt, mdl_fetch);
        chk({tag, "_stall"}, perf_stall_cnt, mdl_stall);
`else
        chk({tag, "_noperf"}, {31'd0, rsp_valid}, 32'd0);
`endif
    endtask

    initial begin
        logic [31:0] pc;
        bit          valid_pc;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_pc    = 32'd0;
        rsp_ready = 1'b0;
        ld_we     = 1'b0;
        ld_addr   = '0;
        ld_data   = 32'd0;
        @(negedge clk);
        // Preload while reset is held; the array must accept these writes.
        for (int i = 0; i < 65; i++) begin
            ld_we   = 1'b1;
            ld_addr = (i == 64) ? ADDR_W'(2**ADDR_W - 1) : i[ADDR_W-1:0];
            ld_data = (i == 0) ? 32'h3402_0001 : $urandom;
            ref_mem[ld_addr] = ld_data;
            @(negedge clk);
        end
        ld_we = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_instr", rsp_instr, 32'd0);
        chk("rst_pc", rsp_pc, 32'd0);
        chk("rst_err", {31'd0, rsp_err}, 32'd0);
        chk_perf("rst_perf");

        fetch(32'h0000_3000, 5, 1'b0, 32'd0);
        chk_perf("stall5");
        fetch(32'h0000_3002, 0, 1'b0, 32'd0);
        fetch(32'h0000_2FFC, 1, 1'b0, 32'd0);
        fetch(32'h0000_7000, 0, 1'b0, 32'd0);
        fetch(32'h0000_6FFC, 0, 1'b0, 32'd0);
        fetch(32'h0000_3004, 2, 1'b1, 32'hDEAD_BEEF);
        chk_perf("directed");

        // Reset while in WAIT drops the transaction.
        req_valid = 1'b1;
        req_pc    = 32'h0000_3000;
        @(negedge clk);
        req_valid = 1'b0;
        pulse_reset();
        chk("wrst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("wrst_ready", {31'd0, req_ready}, 32'd1);
        chk("wrst_instr", rsp_instr, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("wrst_quiet", {31'd0, rsp_valid}, 32'd0);
        end
        fetch(32'h0000_3000, 0, 1'b0, 32'd0);
        chk_perf("after_wrst");

        pulse_reset();
        for (int k = 0; k < 100; k++) begin
            valid_pc = 1'b0;
            case ($urandom % 8)
                0: pc = BASE + 32'(($urandom % 64) * 4 + 1 + $urandom % 3);
                1: pc = 32'($urandom % BASE);
                2: pc = 32'h0000_7000 + 32'($urandom % 32'h1000_0000);
                3: begin pc = 32'h0000_6FFC; valid_pc = 1'b1; end
                default: begin pc = BASE + 32'(($urandom % 64) * 4); valid_pc = 1'b1; end
            endcase
            if ($urandom % 4 == 0) begin
                ld_we   = 1'b1;
                ld_addr = ADDR_W'($urandom % 64);
                ld_data = $urandom;
                ref_mem[ld_addr] = ld_data;
                @(negedge clk);
                ld_we = 1'b0;
            end
            fetch(pc, int'($urandom % 4), valid_pc && ($urandom % 4 == 0), $urandom);
        end
        chk_perf("random");
`ifdef IM_FETCH_PERF_EN
        chk("fetch_100", perf_fetch_cnt, 32'd100);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
